adc_capture: RTL and testbench

SPI receive-side counterpart to the DAC output path: reads dual-channel 14-bit samples from the board's LTC1407A-style ADC. On each `start` request it pulses `ad_conv`, generates `spi_sck`, shifts in the 34-bit frame on `spi_miso`, and presents both channel samples with a one-cycle `valid` strobe. It runs in the fast system clock domain and feeds sample consumers (e.g. a capture memory or loopback checker).

---
 rtl/adc_pkg.sv | 26 ++
 rtl/adc_capture_sck_gen.sv | 37 +++
 rtl/adc_capture.sv | 83 ++++++++
 tb/tb_adc_capture.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared constants, state encoding and frame-field helper for the ADC capture path.
// The 34-bit serial frame is stored MSB-first, so arrival index k lands at bit FRAME_BITS-1-k.
package adc_pkg;

  localparam int FRAME_BITS  = 34;
  localparam int CH0_LSB_IDX = 15;
  localparam int CH1_LSB_IDX = 31;
  localparam int SAMPLE_W    = 14;
  localparam int CONV_PHASES = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONV,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // Extract one channel given the arrival index of its LSB.
  function automatic logic [SAMPLE_W-1:0] frame_field(
    input logic [FRAME_BITS-1:0] frame,
    input int                    lsb_idx
  );
    return frame[FRAME_BITS-1-lsb_idx +: SAMPLE_W];
  endfunction

endpackage

// File: rtl/adc_capture_sck_gen.sv
// SPI serial clock generator: CLK_DIV-cycle low/high phases while enabled, held low otherwise.
// rise/fall flag the clk edge on which spi_sck is about to change.
module sck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic spi_sck,
  output logic rise,
  output logic fall
);

  localparam int              PH_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);

  logic [PH_W-1:0] ph_cnt;
  logic            ph_end;

  assign ph_end = en && (ph_cnt == PH_LAST);
  assign rise   = ph_end && !spi_sck;
  assign fall   = ph_end && spi_sck;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst || !en) begin
      ph_cnt  <= '0;
      spi_sck <= 1'b0;
    end else if (ph_end) begin
      ph_cnt  <= '0;
      spi_sck <= ~spi_sck;
    end else begin
      ph_cnt <= ph_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/adc_capture.sv
// Dual-channel 14-bit SPI ADC reader: conversion strobe, 34-bit frame shift-in, sample strobe.
// Control outputs are registered from the next state so they align exactly with the FSM state.
module adc_capture
  import adc_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int SAMPLE_W = adc_pkg::SAMPLE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                spi_miso,
  output logic                ad_conv,
  output logic                spi_sck,
  output logic                busy,
  output logic [SAMPLE_W-1:0] ch0,
  output logic [SAMPLE_W-1:0] ch1,
  output logic                valid
);

  localparam int              CONV_W    = $clog2(CONV_PHASES * CLK_DIV);
  localparam logic [CONV_W-1:0] CONV_LAST = CONV_W'(CONV_PHASES * CLK_DIV - 1);
  localparam logic [5:0]      LAST_BIT  = 6'(FRAME_BITS - 1);

  state_t                  state_q, state_d;
  logic [CONV_W-1:0]       conv_cnt;
  logic [5:0]              bit_cnt;
  logic [FRAME_BITS-1:0]   sreg;
  logic                    sck_rise, sck_fall;

  sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (state_q == ST_SHIFT),
    .spi_sck (spi_sck),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  // NOTE: next state gets its default first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_CONV;
      ST_CONV:  if (conv_cnt == CONV_LAST) state_d = ST_SHIFT;
      ST_SHIFT: if (sck_fall && bit_cnt == LAST_BIT) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      conv_cnt <= '0;
      bit_cnt  <= '0;
      sreg     <= '0;
      ad_conv  <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      ch0      <= '0;
      ch1      <= '0;
    end else begin
      state_q  <= state_d;
      conv_cnt <= (state_q == ST_CONV) ? conv_cnt + 1'b1 : '0;

      // Bit counter advances on each SCK fall and parks on the final bit.
      if (state_q != ST_SHIFT)                 bit_cnt <= '0;
      else if (sck_fall && bit_cnt != LAST_BIT) bit_cnt <= bit_cnt + 1'b1;

      if (sck_rise) sreg <= {sreg[FRAME_BITS-2:0], spi_miso};

      ad_conv <= (state_d == ST_CONV);
      busy    <= (state_d != ST_IDLE);
      valid   <= (state_d == ST_DONE);
      if (state_d == ST_DONE) begin
        ch0 <= frame_field(sreg, CH0_LSB_IDX);
        ch1 <= frame_field(sreg, CH1_LSB_IDX);
      end
    end
  end

endmodule

// File: tb/tb_adc_capture.sv
// Directed bench for adc_capture: CLK_DIV=2 and CLK_DIV=1 instances, each fed by a behavioural ADC
// that presents frame bit k before SCK rise k (updates right after each rise).
module tb_adc_capture;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  logic        start2 = 1'b0, miso2 = 1'b0;
  logic        ad_conv2, sck2, busy2, valid2;
  logic [13:0] ch0_2, ch1_2;
  logic        start1 = 1'b0, miso1 = 1'b0;
  logic        ad_conv1, sck1, busy1, valid1;
  logic [13:0] ch0_1, ch1_1;

  adc_capture #(.CLK_DIV(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .spi_miso(miso2), .ad_conv(ad_conv2),
    .spi_sck(sck2), .busy(busy2), .ch0(ch0_2), .ch1(ch1_2), .valid(valid2)
  );

  adc_capture #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .spi_miso(miso1), .ad_conv(ad_conv1),
    .spi_sck(sck1), .busy(busy1), .ch0(ch0_1), .ch1(ch1_1), .valid(valid1)
  );

  logic [33:0] frame2 = '0, frame1 = '0;
  int          idx2 = 0, idx1 = 0;

  always @(posedge ad_conv2) begin idx2 = 0; miso2 = frame2[33]; end
  always @(posedge sck2) begin idx2 = idx2 + 1; if (idx2 < 34) miso2 = frame2[33-idx2]; end
  always @(posedge ad_conv1) begin idx1 = 0; miso1 = frame1[33]; end
  always @(posedge sck1) begin idx1 = idx1 + 1; if (idx1 < 34) miso1 = frame1[33-idx1]; end

  int vectors = 0, miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [33:0] mk_frame(input logic dc, input logic [13:0] c0, input logic [13:0] c1);
    return {{2{dc}}, c0, {2{dc}}, c1, {2{dc}}};
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 1) start1 = v; else start2 = v;
  endtask

  // Call right after a negedge; start is sampled on the next posedge (cycle 0).
  task automatic run_frame(input int sel, input int pulse_at,
                           output int v_cyc, output int rises, output int first_rise,
                           output int conv_first, output int conv_last, output int busy_fall,
                           output int valid_cnt, output int high_cnt);
    logic sck, sck_p, bsy, bsy_p, ad, vld;
    v_cyc = -1; rises = 0; first_rise = -1; conv_first = -1; conv_last = -1;
    busy_fall = -1; valid_cnt = 0; high_cnt = 0; sck_p = 1'b0; bsy_p = 1'b0;
    set_start(sel, 1'b1);
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      set_start(sel, n == pulse_at);
      sck = (sel == 1) ? sck1 : sck2;
      bsy = (sel == 1) ? busy1 : busy2;
      ad  = (sel == 1) ? ad_conv1 : ad_conv2;
      vld = (sel == 1) ? valid1 : valid2;
      if (ad) begin if (conv_first < 0) conv_first = n; conv_last = n; end
      if (sck) high_cnt++;
      if (sck && !sck_p) begin rises++; if (first_rise < 0) first_rise = n; end
      if (vld) begin valid_cnt++; if (v_cyc < 0) v_cyc = n; end
      if (bsy_p && !bsy) begin busy_fall = n; break; end
      sck_p = sck; bsy_p = bsy;
    end
    set_start(sel, 1'b0);
  endtask

  int v_cyc, rises, first_rise, conv_first, conv_last, busy_fall, valid_cnt, high_cnt;
  int bad, sckh, vcount, extra;
  int vc[4];
  logic sck_p;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    check("rst_ad_conv", ad_conv2, 0);
    check("rst_sck", sck2, 0);
    check("rst_busy_valid", {busy2, valid2}, 0);
    check("rst_ch0_ch1", {ch0_2, ch1_2}, 0);
    rst = 1'b1;

    // Idle: nothing moves without start
    bad = 0; sckh = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (ad_conv2 | sck2 | busy2 | valid2 | (|ch0_2) | (|ch1_2) |
          ad_conv1 | sck1 | busy1 | valid1 | (|ch0_1) | (|ch1_1)) bad++;
      if (sck2 | sck1) sckh++;
    end
    check("idle_nonzero_cycles", bad, 0);
    check("idle_sck_high_cycles", sckh, 0);

    // Frame A, CLK_DIV=2
    frame2 = mk_frame(1'b0, 14'h1ABC, 14'h2001);
    run_frame(0, 0, v_cyc, rises, first_rise, conv_first, conv_last, busy_fall, valid_cnt, high_cnt);
    check("a_valid_cycle", v_cyc, 141);
    check("a_valid_count", valid_cnt, 1);
    check("a_sck_rises", rises, 34);
    check("a_first_rise", first_rise, 7);
    check("a_sck_high_cycles", high_cnt, 68);
    check("a_conv_first", conv_first, 1);
    check("a_conv_last", conv_last, 4);
    check("a_busy_fall", busy_fall, 142);
    check("a_ch0", ch0_2, 14'h1ABC);
    check("a_ch1", ch1_2, 14'h2001);

    // Frame B: don't-care bits set, extreme samples
    frame2 = mk_frame(1'b1, 14'h0000, 14'h3FFF);
    run_frame(0, 0, v_cyc, rises, first_rise, conv_first, conv_last, busy_fall, valid_cnt, high_cnt);
    check("b_ch0", ch0_2, 14'h0000);
    check("b_ch1", ch1_2, 14'h3FFF);
    check("b_valid_cycle", v_cyc, 141);

    // start held high: back-to-back frames every 142 cycles
    frame2 = mk_frame(1'b0, 14'h1ABC, 14'h2001);
    start2 = 1'b1; vcount = 0;
    for (int n = 1; n <= 450; n++) begin
      @(negedge clk);
      if (valid2) begin if (vcount < 4) vc[vcount] = n; vcount++; end
    end
    start2 = 1'b0;
    for (int n = 0; n < 200 && busy2; n++) @(negedge clk);
    check("hold_valid_count", vcount, 3);
    check("hold_first_valid", vc[0], 141);
    check("hold_period_1", vc[1] - vc[0], 142);
    check("hold_period_2", vc[2] - vc[1], 142);
    check("hold_busy_settled", busy2, 0);

    // start pulsed mid-SHIFT: no extra frame
    run_frame(0, 50, v_cyc, rises, first_rise, conv_first, conv_last, busy_fall, valid_cnt, high_cnt);
    check("pulse_valid_count", valid_cnt, 1);
    check("pulse_busy_fall", busy_fall, 142);
    extra = 0;
    for (int n = 0; n < 200; n++) begin @(negedge clk); if (valid2 | busy2) extra++; end
    check("pulse_no_extra_frame", extra, 0);

    // Reset asserted at the 20th SCK rise
    frame2 = mk_frame(1'b0, 14'h2555, 14'h0AAA);
    start2 = 1'b1; rises = 0; sck_p = 1'b0;
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (sck2 && !sck_p) rises++;
      sck_p = sck2;
      if (rises == 20) break;
    end
    check("mid_reached_rise20", rises, 20);
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ad_conv_sck", {ad_conv2, sck2}, 0);
    check("mid_rst_busy_valid", {busy2, valid2}, 0);
    check("mid_rst_ch0", ch0_2, 0);
    check("mid_rst_ch1", ch1_2, 0);
    rst = 1'b1;
    @(negedge clk);
    run_frame(0, 0, v_cyc, rises, first_rise, conv_first, conv_last, busy_fall, valid_cnt, high_cnt);
    check("post_rst_rises", rises, 34);
    check("post_rst_ch0", ch0_2, 14'h2555);
    check("post_rst_ch1", ch1_2, 14'h0AAA);

    // CLK_DIV=1 instance
    frame1 = mk_frame(1'b0, 14'h0F0F, 14'h30C3);
    run_frame(1, 0, v_cyc, rises, first_rise, conv_first, conv_last, busy_fall, valid_cnt, high_cnt);
    check("d1_valid_cycle", v_cyc, 71);
    check("d1_sck_rises", rises, 34);
    check("d1_first_rise", first_rise, 4);
    check("d1_sck_high_cycles", high_cnt, 34);
    check("d1_conv_window", {conv_first[15:0], conv_last[15:0]}, {16'd1, 16'd2});
    check("d1_busy_fall", busy_fall, 72);
    check("d1_ch0", ch0_1, 14'h0F0F);
    check("d1_ch1", ch1_1, 14'h30C3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
